data_mem_pipe: RTL and testbench

`data_mem_pipe` is the parametrised, pipelined data memory behind the core's load/store stage. It provides:
- byte-addressable little-endian storage with byte, halfword and word accesses, including sign/zero extension on loads;
- a configurable read latency with one request accepted per cycle, and in-order acknowledgement of every request;
- an error response for malformed or misaligned accesses.

---
 rtl/data_mem_pipe.sv | 118 +++++++++++
 tb/tb_data_mem_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressable little-endian data memory with a fixed-latency, in-order response pipeline.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module data_mem_pipe #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stb,
    output logic                  o_ready,
    input  logic                  i_wr_en,
    input  logic [2:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_write_data,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [31:0]           o_read_data
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    // Handshake: a request transfers on a rising edge with i_stb && o_ready. o_ready is
    // simply !rst, and each transfer produces exactly one o_ack READ_LATENCY cycles later.
    logic accept;
    assign o_ready = ~rst;
    assign accept  = i_stb & o_ready;

    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr;

    logic [7:0]       mem [DEPTH_BYTES];
    logic [IDX_W-1:0] idx [4];

    // Byte lanes sit at consecutive indices; the IDX_W-bit add wraps modulo DEPTH_BYTES.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = i_addr[IDX_W-1:0] + IDX_W'(k);
        end
    end

    logic size_bad;
    logic misalign;
    logic req_err;
    logic wr_ok;

    always_comb begin
        size_bad = (i_size == 3'b011) || (i_size[2:1] == 2'b11) || (i_wr_en && i_size[2]);
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = ((i_size[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_size[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = size_bad || misalign;
    end

    assign wr_ok = accept && i_wr_en && !req_err;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[idx[0]] <= i_write_data[7:0];
            if (i_size[1:0] != 2'b00) begin
                mem[idx[1]] <= i_write_data[15:8];
            end
            if (i_size[1:0] == 2'b10) begin
                mem[idx[2]] <= i_write_data[23:16];
                mem[idx[3]] <= i_write_data[31:24];
            end
        end
    end

    logic [31:0] raw;
    logic [31:0] load_data;

    always_comb begin
        raw       = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
        load_data = 32'd0;
        if (accept && !i_wr_en && !req_err) begin
            case (i_size)
                3'b000:  load_data = {{24{raw[7]}}, raw[7:0]};
                3'b001:  load_data = {{16{raw[15]}}, raw[15:0]};
                3'b010:  load_data = raw;
                3'b100:  load_data = {24'd0, raw[7:0]};
                3'b101:  load_data = {16'd0, raw[15:0]};
                default: load_data = 32'd0;
            endcase
        end
    end

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_err;
    logic [31:0]             pipe_data [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_data[s] <= 32'd0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && req_err;
            pipe_data[0]  <= load_data;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_err[s]   <= pipe_err[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    assign o_ack       = pipe_valid[READ_LATENCY-1];
    assign o_err       = pipe_err[READ_LATENCY-1];
    assign o_read_data = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe (READ_LATENCY=3): directed steps plus random traffic against a byte-array model.
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_data_mem_pipe;
    localparam int L     = 3;
    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic        i_stb;
    logic        o_ready;
    logic        i_wr_en;
    logic [2:0]  i_size;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic        o_ack;
    logic        o_err;
    logic [31:0] o_read_data;

    data_mem_pipe #(
        .ADDR_WIDTH  (32),
        .DEPTH_BYTES (DEPTH),
        .READ_LATENCY(L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_stb       (i_stb),
        .o_ready     (o_ready),
        .i_wr_en     (i_wr_en),
        .i_size      (i_size),
        .i_addr      (i_addr),
        .i_write_data(i_write_data),
        .o_ack       (o_ack),
        .o_err       (o_err),
        .o_read_data (o_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_m [DEPTH];
    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [32:0] obs_q[$];
    int          obs_cyc[$];

    function automatic bit model_err(input bit wr, input logic [2:0] sz, input int idx);
        if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) return 1'b1;
        if (wr && (sz == 3'b100 || sz == 3'b101)) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if ((sz == 3'b001 || sz == 3'b101) && (idx % 2) != 0) return 1'b1;
        if (sz == 3'b010 && (idx % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'b000 || sz == 3'b100) return 1;
        if (sz == 3'b001 || sz == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) w = w | (32'(mem_m[(idx + k) % DEPTH]) << (8 * k));
        return w;
    endfunction

    function automatic logic [32:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 33'h1_DEAD_0BAD;
    endfunction

    function automatic int obs_cyc_at(input int i);
        if (i < obs_cyc.size()) return obs_cyc[i];
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One request: the model decides its outcome before the acceptance edge.
    task automatic req(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd);
        int          idx;
        bit          e;
        longint      v;
        logic [31:0] rd;
        idx = int'(addr % DEPTH);
        e   = model_err(wr, sz, idx);
        v   = 0;
        rd  = 32'd0;
        if (!e) begin
            if (wr) begin
                for (int k = 0; k < nbytes(sz); k++) mem_m[(idx + k) % DEPTH] = 8'(wd >> (8 * k));
            end else begin
                for (int k = 0; k < nbytes(sz); k++)
                    v += longint'(mem_m[(idx + k) % DEPTH]) << (8 * k);
                if (sz == 3'b000 && v >= 128) v -= 256;
                if (sz == 3'b001 && v >= 32768) v -= 65536;
                rd = v[31:0];
            end
        end
        i_stb        = 1'b1;
        i_wr_en      = wr;
        i_size       = sz;
        i_addr       = addr;
        i_write_data = wd;
        @(posedge clk);
        #1;
        exp_q.push_back({e, rd});
        exp_cyc_q.push_back(cyc + L - 1);
    endtask

    task automatic drain();
        int t;
        t     = 0;
        i_stb = 1'b0;
        while (exp_q.size() != 0 && t < L + 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0 pending acks", exp_q.size());
        end
    endtask

    logic        exp_ack;
    logic [32:0] exp_e;

    always @(negedge clk) begin
        exp_ack = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        n_checks++;
        assert (o_ready === ~rst) else begin
            n_fail++;
            $error("FAIL ready observed=%b expected=%b", o_ready, ~rst);
        end
        n_checks++;
        assert (o_ack === exp_ack) else begin
            n_fail++;
            $error("FAIL ack_timing cyc=%0d observed=%b expected=%b", cyc, o_ack, exp_ack);
        end
        if (exp_ack) begin
            exp_e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            n_checks++;
            assert ({o_err, o_read_data} === exp_e) else begin
                n_fail++;
                $error("FAIL response cyc=%0d observed=%h expected=%h", cyc, {o_err, o_read_data}, exp_e);
            end
        end
        if (rst) begin
            n_checks++;
            assert ({o_ack, o_err, o_read_data} === 34'd0) else begin
                n_fail++;
                $error("FAIL rst_outputs observed=%h expected=0", {o_ack, o_err, o_read_data});
            end
        end
        if (o_ack === 1'b1) begin
            obs_q.push_back({o_err, o_read_data});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lo_prev;
        logic [31:0] w104;
        logic [32:0] o;
        int          n0;
        logic [31:0] base;
        logic [31:0] addr;

        rst = 1'b1; i_stb = 1'b0; i_wr_en = 1'b0; i_size = 3'b000;
        i_addr = 32'd0; i_write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_ready, o_ack, o_err, o_read_data[29:0]}, 33'd0);
        chk("reset_data", {1'b0, o_read_data}, 33'd0);
        rst = 1'b0;

        for (int a = 0; a < 'h300; a += 4) req(1'b1, 3'b010, 32'(a), $urandom);
        for (int a = 'hF00; a < 'h1000; a += 4) req(1'b1, 3'b010, 32'(a), $urandom);
        drain();

        obs_q.delete(); obs_cyc.delete();
        req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        req(1'b0, 3'b010, 32'h100, 32'd0);
        req(1'b0, 3'b100, 32'h103, 32'd0);
        req(1'b0, 3'b000, 32'h103, 32'd0);
        drain();
        chk("sw_resp", obs_at(0), {1'b0, 32'h0});
        chk("lw_100", obs_at(1), {1'b0, 32'hDEADBEEF});
        chk("lbu_103", obs_at(2), {1'b0, 32'h000000DE});
        chk("lb_103", obs_at(3), {1'b0, 32'hFFFFFFDE});

        lo_prev = model_word('h200);
        obs_q.delete(); obs_cyc.delete();
        req(1'b1, 3'b001, 32'h202, 32'h00008001);
        req(1'b0, 3'b001, 32'h202, 32'd0);
        req(1'b0, 3'b101, 32'h202, 32'd0);
        req(1'b0, 3'b010, 32'h200, 32'd0);
        drain();
        chk("lh_202", obs_at(1), {1'b0, 32'hFFFF8001});
        chk("lhu_202", obs_at(2), {1'b0, 32'h00008001});
        chk("lw_200", obs_at(3), {1'b0, 16'h8001, lo_prev[15:0]});

        w104 = model_word('h104);
        obs_q.delete(); obs_cyc.delete();
        req(1'b0, 3'b011, 32'h100, 32'd0);
        req(1'b1, 3'b110, 32'h104, 32'h12345678);
        req(1'b1, 3'b100, 32'h108, 32'h000000AB);
        req(1'b0, 3'b010, 32'h1100, 32'd0);
        req(1'b0, 3'b010, 32'h104, 32'd0);
        drain();
        chk("ld_size011", obs_at(0), {1'b1, 32'h0});
        chk("st_size110", obs_at(1), {1'b1, 32'h0});
        chk("st_size100", obs_at(2), {1'b1, 32'h0});
        chk("alias_1100", obs_at(3), {1'b0, 32'hDEADBEEF});
        chk("err_st_nowrite", obs_at(4), {1'b0, w104});

        obs_q.delete(); obs_cyc.delete();
        req(1'b0, 3'b010, 32'h100, 32'd0);
        n0 = cyc;
        for (int i = 1; i < 5; i++) req(1'b0, 3'b010, 32'(32'h100 + 4 * i), 32'd0);
        drain();
        chk("b2b_count", 33'(obs_q.size()), 33'd5);
        for (int i = 0; i < 5; i++) chk("b2b_cycle", 33'(obs_cyc_at(i)), 33'(n0 + L - 1 + i));
        chk("b2b_first", obs_at(0), {1'b0, 32'hDEADBEEF});

        obs_q.delete(); obs_cyc.delete();
        req(1'b1, 3'b010, 32'h240, 32'h55AA1234);
        req(1'b0, 3'b010, 32'h240, 32'd0);
        drain();
        chk("raw_240", obs_at(1), {1'b0, 32'h55AA1234});

        w104 = model_word('h104);
        obs_q.delete(); obs_cyc.delete();
        req(1'b1, 3'b010, 32'h101, 32'h11223344);
        req(1'b0, 3'b100, 32'h101, 32'd0);
        req(1'b0, 3'b010, 32'h100, 32'd0);
        req(1'b0, 3'b010, 32'h104, 32'd0);
        drain();
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misal_sw", obs_at(0), {1'b1, 32'h0});
        chk("misal_lbu", obs_at(1), {1'b0, 32'h000000BE});
        chk("misal_lw100", obs_at(2), {1'b0, 32'hDEADBEEF});
        chk("misal_lw104", obs_at(3), {1'b0, w104});
`else
        chk("misal_sw", obs_at(0), {1'b0, 32'h0});
        chk("misal_lbu", obs_at(1), {1'b0, 32'h00000044});
        chk("misal_lw100", obs_at(2), {1'b0, 32'h223344EF});
        chk("misal_lw104", obs_at(3), {1'b0, w104[31:8], 8'h11});
`endif

        req(1'b1, 3'b010, 32'h180, 32'hCAFEF00D);
        drain();
        obs_q.delete(); obs_cyc.delete();
        req(1'b0, 3'b010, 32'h180, 32'd0);
        req(1'b0, 3'b010, 32'h184, 32'd0);
        i_stb = 1'b0;
        rst   = 1'b1;
        exp_q.delete(); exp_cyc_q.delete();
        #1;
        chk("midrst_outputs", {o_ready, o_ack, o_err, o_read_data[29:0]}, 33'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_no_ack", 33'(obs_q.size()), 33'd0);
        req(1'b0, 3'b010, 32'h180, 32'd0);
        drain();
        chk("post_rst_lw", obs_at(0), {1'b0, 32'hCAFEF00D});

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                i_stb = 1'b0;
                @(posedge clk);
                #1;
            end
            base = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 'h2F0))
                                               : 32'($urandom_range('hF00, 'hFFF));
            addr = base | (32'($urandom_range(0, 15)) << 12);
            req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
